// File: rtl/spi_byte_shifter_if.sv
// FIFO-side strobe/data and SPI-side frame signals of spi_byte_shifter.
// slave = the shifter itself, master = the FIFO/WiFi side that drives it.
interface spi_byte_shifter_if;
  logic       rd_clk;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic       mosi;
  logic       cs_n;
  logic       pkt_done;
  logic       underrun;

  modport master (
    output rd_clk, fifo_dout, fifo_empty,
    input  fifo_rd_en, mosi, cs_n, pkt_done, underrun
  );

  modport slave (
    input  rd_clk, fifo_dout, fifo_empty,
    output fifo_rd_en, mosi, cs_n, pkt_done, underrun
  );
endinterface

// File: rtl/spi_byte_shifter.sv
// Byte-to-serial SPI shifter: reads the TX FIFO on rd_clk strobes and emits fixed-length cs_n frames.
// Define FRAME_HEADER_EN to prepend HDR_BYTE to every frame (first slot does not read the FIFO).
module spi_byte_shifter #(
  parameter int         PKT_BYTES = 256,
  parameter logic [7:0] HDR_BYTE  = 8'hA5
) (
  input  logic              sck,
  input  logic              sys_rst_n,
  spi_byte_shifter_if.slave bus
);

  localparam int CW = $clog2(PKT_BYTES + 2);
`ifdef FRAME_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif
  localparam logic [CW-1:0] LAST_CNT = CW'(PKT_BYTES + int'(HDR_EN));

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;
  // Action decided on the strobe edge, carried out one edge later when FIFO data is valid.
  typedef enum logic [2:0] {ACT_NONE, ACT_FIFO, ACT_ZERO, ACT_HDR, ACT_CLOSE} act_e;

  state_e        state_q, state_d;
  act_e          act_q, act_d;
  logic [CW-1:0] byte_cnt_q;
  logic [7:0]    sr_q;
  logic [7:0]    load_byte;
  logic          mosi_q, cs_n_q, pkt_done_q, underrun_q;
  logic          rd_en, last_slot;

  assign last_slot = (byte_cnt_q == LAST_CNT);
  assign load_byte = (act_q == ACT_HDR)  ? HDR_BYTE :
                     (act_q == ACT_ZERO) ? 8'h00    : bus.fifo_dout;

  always_comb begin
    state_d = state_q;
    act_d   = ACT_NONE;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (act_q != ACT_NONE) begin
          state_d = SHIFT;
        end else if (bus.rd_clk && !bus.fifo_empty) begin
          act_d = HDR_EN ? ACT_HDR : ACT_FIFO;
          rd_en = !HDR_EN;
        end
      end
      SHIFT: begin
        if (act_q == ACT_CLOSE) begin
          state_d = GAP;
        end else if (bus.rd_clk) begin
          if (last_slot) begin
            act_d = ACT_CLOSE;
          end else if (!bus.fifo_empty) begin
            act_d = ACT_FIFO;
            rd_en = 1'b1;
          end else begin
            act_d = ACT_ZERO;
          end
        end
      end
      GAP: begin
        // One swallowed strobe guarantees 16 sck of cs_n high between frames.
        if (bus.rd_clk) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sck or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      act_q   <= ACT_NONE;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
    end
  end

  always_ff @(posedge sck or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      byte_cnt_q <= '0;
      sr_q       <= '0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      pkt_done_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      pkt_done_q <= (act_q == ACT_CLOSE);
      case (act_q)
        ACT_FIFO, ACT_ZERO, ACT_HDR: begin
          mosi_q     <= load_byte[7];
          sr_q       <= {load_byte[6:0], 1'b0};
          cs_n_q     <= 1'b0;
          byte_cnt_q <= (state_q == IDLE) ? CW'(1) : byte_cnt_q + CW'(1);
          if (act_q == ACT_ZERO) underrun_q <= 1'b1;
        end
        ACT_CLOSE: begin
          cs_n_q <= 1'b1;
          mosi_q <= 1'b0;
          sr_q   <= '0;
        end
        default: begin
          mosi_q <= (state_q == SHIFT) && sr_q[7];
          sr_q   <= {sr_q[6:0], 1'b0};
          if (state_q == IDLE) byte_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.mosi       = mosi_q;
  assign bus.cs_n       = cs_n_q;
  assign bus.pkt_done   = pkt_done_q;
  assign bus.underrun   = underrun_q;

  a_no_read_empty: assert property (@(posedge sck) disable iff (!sys_rst_n)
    bus.fifo_rd_en |-> !bus.fifo_empty);
  a_cnt_bound: assert property (@(posedge sck) disable iff (!sys_rst_n)
    byte_cnt_q <= LAST_CNT);

endmodule
